// File: rtl/load_store_unit.sv
// RV32 load/store unit: sequences byte/half/word accesses onto a word-wide data cache,
// using read-modify-write for sub-word stores and sign/zero extension for loads.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        cache_read,
  output logic        cache_write,
  output logic [31:0] cache_address,
  output logic [31:0] cache_writedata,
  input  logic [31:0] cache_readdata,
  input  logic        cache_busywait
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] LOAD        = 3'd1;
  localparam logic [2:0] STORE_READ  = 3'd2;
  localparam logic [2:0] STORE_WRITE = 3'd3;
  localparam logic [2:0] DONE        = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  logic request, illegal, unaligned, valid, in_idle;

  function automatic logic [31:0] extend(input logic [2:0]  f3,
                                         input logic [1:0]  lane,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {24'h000000, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b101:  extend = {16'h0000, h};
      default: extend = word;
    endcase
  endfunction

  // Sub-word store: overwrite only the addressed lane of the word read back from the cache.
  function automatic logic [31:0] merge(input logic [2:0]  f3,
                                        input logic [1:0]  lane,
                                        input logic [31:0] word,
                                        input logic [31:0] sd);
    merge = word;
    if (f3[0]) begin
      if (lane[1]) merge[31:16] = sd[15:0];
      else         merge[15:0]  = sd[15:0];
    end else begin
      merge[{lane, 3'b000} +: 8] = sd[7:0];
    end
  endfunction

  always_comb begin
    request   = mem_read | mem_write;
    illegal   = (mem_read & mem_write) |
                (mem_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11))) |
                (mem_write & (funct3 >= 3'b011));
    unaligned = ((funct3[1:0] == 2'b01) & address[0]) |
                ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00));
    valid     = request & ~illegal & ~unaligned;
    in_idle   = (state_q == IDLE);
  end

  // Gated by reset so that arbitrary inputs during reset never raise a flag.
  assign misaligned = reset & in_idle & request & (illegal | unaligned);
  assign stall      = reset & ((state_q == LOAD) | (state_q == STORE_READ) |
                               (state_q == STORE_WRITE) | (in_idle & valid));

  assign cache_read      = (state_q == LOAD) | (state_q == STORE_READ);
  assign cache_write     = (state_q == STORE_WRITE);
  assign cache_address   = {addr_q[31:2], 2'b00};
  assign cache_writedata = wdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          if (mem_read)               state_d = LOAD;
          else if (funct3 == 3'b010)  state_d = STORE_WRITE;
          else                        state_d = STORE_READ;
        end
      end
      LOAD:        if (!cache_busywait) state_d = DONE;
      STORE_READ:  if (!cache_busywait) state_d = STORE_WRITE;
      STORE_WRITE: if (!cache_busywait) state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      funct3_q  <= 3'b000;
      wdata_q   <= 32'h0;
      load_data <= 32'h0;
    end else begin
      state_q <= state_d;
      if (in_idle && valid) begin
        addr_q   <= address;
        funct3_q <= funct3;
        wdata_q  <= store_data;
      end
      if ((state_q == LOAD) && !cache_busywait) begin
        load_data <= extend(funct3_q, addr_q[1:0], cache_readdata);
      end
      if ((state_q == STORE_READ) && !cache_busywait) begin
        wdata_q <= merge(funct3_q, addr_q[1:0], cache_readdata, wdata_q);
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected cache transactions and
// load results; a negedge monitor pops and compares as the DUT presents them.
module tb_load_store_unit;

  localparam int KRD   = 0;
  localparam int KWR   = 1;
  localparam int KDONE = 2;
  localparam int KMIS  = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic [31:0] load_data;
  logic        stall, misaligned, cache_read, cache_write;
  logic [31:0] cache_address, cache_writedata, cache_readdata;
  logic        cache_busywait;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  logic prev_stall = 1'b0;

  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  int          wait_cnt = 0;
  int          bw_cfg = 0;

  load_store_unit dut (
    .clock           (clock),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .funct3          (funct3),
    .address         (address),
    .store_data      (store_data),
    .load_data       (load_data),
    .stall           (stall),
    .misaligned      (misaligned),
    .cache_read      (cache_read),
    .cache_write     (cache_write),
    .cache_address   (cache_address),
    .cache_writedata (cache_writedata),
    .cache_readdata  (cache_readdata),
    .cache_busywait  (cache_busywait)
  );

  always #5 clock = ~clock;

  // Cache model: busywait holds for bw_cfg cycles at the start of each request.
  assign cache_readdata = mem[cache_address[9:2]];
  assign cache_busywait = (cache_read | cache_write) && (wait_cnt != 0);

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h5555_5555;
      mem[64]  = 32'h8765_4321;
      mem[128] = 32'h1122_3344;
    end else if (cache_write && !cache_busywait) begin
      mem[cache_address[9:2]] = cache_writedata;
    end
    if (!(cache_read || cache_write) || !cache_busywait) wait_cnt <= bw_cfg;
    else wait_cnt <= wait_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic expect_event(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event got kind=%0d addr=%h data=%h expected none", kind, a, d);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == kind) begin
        if (kind == KRD || kind == KWR) chk("cache_address", a, e.addr);
        if (kind == KWR || kind == KDONE) chk("event_data", d, e.data);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (cache_read && cache_write) chk("strobe_overlap", 32'd1, 32'd0);
      if (misaligned) begin
        expect_event(KMIS, address, 32'h0);
        chk("mis_no_side_effect", {29'b0, stall, cache_read, cache_write}, 32'd0);
      end
      if (cache_read && !cache_busywait) expect_event(KRD, cache_address, 32'h0);
      if (cache_write && !cache_busywait) expect_event(KWR, cache_address, cache_writedata);
      if (prev_stall && !stall) begin
        expect_event(KDONE, 32'h0, load_data);
        chk("done_no_strobe", {30'b0, cache_read, cache_write}, 32'd0);
      end
      prev_stall = stall;
    end
  end

  task automatic clear_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b111;
    address    = 32'hFFFF_FFFF;
    store_data = 32'h5A5A_5A5A;
  endtask

  // Present one access for a single cycle, scramble the inputs, then wait for stall to drop.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, output int n);
    @(posedge clock); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; address = a; store_data = sd;
    @(posedge clock); #1;
    clear_inputs();
    n = 0;
    while (stall && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (stall) chk("access_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_load_data"}, load_data, 32'h0);
    chk({tag, "_flags"}, {28'b0, stall, misaligned, cache_read, cache_write}, 32'h0);
    chk({tag, "_cache_address"}, cache_address, 32'h0);
    chk({tag, "_cache_writedata"}, cache_writedata, 32'h0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    int n;
    push(KRD, {a[31:2], 2'b00}, 32'h0);
    push(KDONE, 32'h0, exp);
    access(1'b1, 1'b0, f3, a, 32'h0, n);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] word, input logic [31:0] ld);
    int n;
    if (f3 != 3'b010) push(KRD, {a[31:2], 2'b00}, 32'h0);
    push(KWR, {a[31:2], 2'b00}, word);
    push(KDONE, 32'h0, ld);
    access(1'b0, 1'b1, f3, a, sd, n);
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int n;
    push(KMIS, 32'h0, 32'h0);
    access(rd, wr, f3, a, 32'h1234_5678, n);
  endtask

  initial begin
    int n;
    // Reset with arbitrary inputs.
    mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b011;
    address = 32'h0000_0101; store_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    #1;
    mem_init = 1'b1;
    check_all_zero("in_reset");
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("idle_after_reset");

    bw_cfg = 3;
    load(3'b010, 32'h100, 32'h8765_4321);
    bw_cfg = 0;
    store(3'b010, 32'h100, 32'h80FF_1234, 32'h80FF_1234, 32'h8765_4321);
    bw_cfg = 1;
    load(3'b000, 32'h103, 32'hFFFF_FF80);
    bw_cfg = 0;
    load(3'b100, 32'h103, 32'h0000_0080);
    load(3'b001, 32'h102, 32'hFFFF_80FF);
    load(3'b101, 32'h100, 32'h0000_1234);

    bw_cfg = 2;
    store(3'b000, 32'h201, 32'h0000_00AB, 32'h1122_AB44, 32'h0000_1234);
    bw_cfg = 0;
    store(3'b001, 32'h202, 32'hCAFE_BEEF, 32'hBEEF_AB44, 32'h0000_1234);
    bw_cfg = 1;
    store(3'b010, 32'h204, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_1234);
    bw_cfg = 0;
    load(3'b010, 32'h200, 32'hBEEF_AB44);
    load(3'b001, 32'h200, 32'hFFFF_AB44);
    load(3'b000, 32'h201, 32'hFFFF_FFAB);
    load(3'b101, 32'h202, 32'h0000_BEEF);
    load(3'b100, 32'h204, 32'h0000_00EF);
    load(3'b001, 32'h206, 32'hFFFF_DEAD);

    // Zero-wait latency: cycles spent stalled after acceptance.
    push(KRD, 32'h100, 32'h0);
    push(KDONE, 32'h0, 32'h80FF_1234);
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, n);
    chk("lw_latency", 32'(n), 32'd1);
    push(KRD, 32'h200, 32'h0);
    push(KWR, 32'h200, 32'hBEEF_AB77);
    push(KDONE, 32'h0, 32'h80FF_1234);
    access(1'b0, 1'b1, 3'b000, 32'h200, 32'h0000_0077, n);
    chk("sb_latency", 32'(n), 32'd2);

    bad(1'b1, 1'b0, 3'b001, 32'h101);
    bad(1'b0, 1'b1, 3'b010, 32'h202);
    bad(1'b1, 1'b0, 3'b011, 32'h100);
    bad(1'b1, 1'b1, 3'b010, 32'h100);
    bad(1'b0, 1'b1, 3'b100, 32'h100);
    bad(1'b1, 1'b0, 3'b010, 32'h102);
    bad(1'b1, 1'b0, 3'b110, 32'h100);

    // Reset during a stalled word write.
    bw_cfg = 10;
    @(posedge clock); #1;
    mem_write = 1'b1; funct3 = 3'b010; address = 32'h208; store_data = 32'h1234_5678;
    @(posedge clock); #1;
    clear_inputs();
    chk("sw_write_strobe", {31'b0, cache_write}, 32'd1);
    @(posedge clock); #1;
    chk("sw_stall", {31'b0, stall}, 32'd1);
    #2;
    reset = 1'b0;
    mem_read = 1'b1; funct3 = 3'b011; address = 32'h101;
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clock);
    #1;
    clear_inputs();
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("no_retry_write", {30'b0, cache_read, cache_write}, 32'd0);
    chk("no_partial_write", mem[130], 32'h5555_5555);
    bw_cfg = 0;
    load(3'b010, 32'h204, 32'hDEAD_BEEF);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
